register_file: RTL and testbench

- CPU general-purpose register file and status register (R0–R15) sitting directly downstream of the ALU.
- Captures `alu_out` into the decoded destination register and merges `alu_stat`/`alu_stat_wr` into R2 (SR).
- Performs source/destination autoincrement and stack-pointer updates.
- Returns the source and destination operands that feed the ALU's `op_src`/`op_dst` on the next instruction.
- R0 (PC) is owned by the frontend; writes to R0 are forwarded to it as a software PC load.

---
 rtl/register_file_pkg.sv | 37 +++
 rtl/register_file.sv | 128 ++++++++++++
 tb/tb_register_file.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared register-file definitions: SR bit positions, register indices and
// the {V,N,Z,C} flag ordering used by both the ALU and the register file.
package register_file_pkg;

  // Status register bit positions
  localparam int SR_C      = 0;
  localparam int SR_Z      = 1;
  localparam int SR_N      = 2;
  localparam int SR_GIE    = 3;
  localparam int SR_CPUOFF = 4;
  localparam int SR_OSCOFF = 5;
  localparam int SR_SCG0   = 6;
  localparam int SR_SCG1   = 7;
  localparam int SR_V      = 8;

  // Architectural register indices with special behaviour
  localparam int REG_PC  = 0;
  localparam int REG_SP  = 1;
  localparam int REG_SR  = 2;
  localparam int REG_CG2 = 3;

  // Position of each flag inside the 4-bit {V,N,Z,C} flag vectors
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  // SR control bits cleared when an interrupt is accepted (SCG0 survives)
  localparam logic [8:0] SR_IRQ_CLEAR_MASK =
    (9'h1 << SR_GIE) | (9'h1 << SR_CPUOFF) | (9'h1 << SR_OSCOFF) | (9'h1 << SR_SCG1);

  // Pack the SR flags into the {V,N,Z,C} order the ALU expects
  function automatic logic [3:0] sr_to_status(input logic [8:0] sr);
    return {sr[SR_V], sr[SR_N], sr[SR_Z], sr[SR_C]};
  endfunction

endpackage

// File: rtl/register_file.sv
// General-purpose register file R0-R15 with status register merge,
// autoincrement, stack-pointer load and software PC load strobe.
module register_file
  import register_file_pkg::*;
(
  input  logic        mclk,
  input  logic        reset_n,
  input  logic [15:0] alu_out,
  input  logic [3:0]  alu_stat,
  input  logic [3:0]  alu_stat_wr,
  input  logic        inst_bw,
  input  logic [15:0] inst_src,
  input  logic [15:0] inst_dest,
  input  logic        reg_dest_wr,
  input  logic        reg_incr,
  input  logic        reg_sp_wr,
  input  logic [15:0] reg_sp_val,
  input  logic        irq_acc,
  input  logic [15:0] pc,
  output logic [15:0] reg_src,
  output logic [15:0] reg_dest,
  output logic [3:0]  status,
  output logic        gie,
  output logic        cpuoff,
  output logic        oscoff,
  output logic        scg1,
  output logic [15:0] pc_sw,
  output logic        pc_sw_wr
);

  logic [15:0]       dest_data;
  logic [15:0]       incr_step;
  logic [15:0]       r1;
  logic [8:0]        sr;
  logic [8:0]        sr_next;
  logic [15:0][15:0] reg_view;

  // Byte instructions write a zero-extended low byte
  assign dest_data = inst_bw ? {8'h00, alu_out[7:0]} : alu_out;
  assign incr_step = inst_bw ? 16'd1 : 16'd2;

  // SP: destination write beats SP load beats autoincrement; always word aligned
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r1 <= '0;
    end else if (reg_dest_wr && inst_dest[REG_SP]) begin
      r1 <= dest_data & 16'hFFFE;
    end else if (reg_sp_wr) begin
      r1 <= reg_sp_val & 16'hFFFE;
    end else if (reg_incr && inst_src[REG_SP]) begin
      r1 <= r1 + 16'd2;
    end
  end

  // SR next value: flags lowest, then increment, then full write, irq clear on top
  always_comb begin
    sr_next = sr;
    if (alu_stat_wr[FLAG_C]) sr_next[SR_C] = alu_stat[FLAG_C];
    if (alu_stat_wr[FLAG_Z]) sr_next[SR_Z] = alu_stat[FLAG_Z];
    if (alu_stat_wr[FLAG_N]) sr_next[SR_N] = alu_stat[FLAG_N];
    if (alu_stat_wr[FLAG_V]) sr_next[SR_V] = alu_stat[FLAG_V];
    if (reg_incr && inst_src[REG_SR]) sr_next = sr + incr_step[8:0];
    if (reg_dest_wr && inst_dest[REG_SR]) sr_next = dest_data[8:0];
    if (irq_acc) sr_next = sr_next & ~SR_IRQ_CLEAR_MASK;
  end

  // SR storage, only the nine implemented bits
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else begin
      sr <= sr_next;
    end
  end

  // Software PC load: R0 writes are handed to the frontend with a one-cycle strobe
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      pc_sw    <= '0;
      pc_sw_wr <= 1'b0;
    end else begin
      pc_sw_wr <= reg_dest_wr & inst_dest[REG_PC];
      if (reg_dest_wr && inst_dest[REG_PC]) begin
        pc_sw <= alu_out;
      end
    end
  end

  // R4-R15 are plain registers with write and autoincrement
  for (genvar i = 4; i < 16; i++) begin : g_gpr
    logic [15:0] value;

    // Destination write has priority over autoincrement
    always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
        value <= '0;
      end else if (reg_dest_wr && inst_dest[i]) begin
        value <= dest_data;
      end else if (reg_incr && inst_src[i]) begin
        value <= value + incr_step;
      end
    end

    assign reg_view[i] = value;
  end

  assign reg_view[REG_PC]  = pc;
  assign reg_view[REG_SP]  = r1;
  assign reg_view[REG_SR]  = {7'b0, sr};
  assign reg_view[REG_CG2] = '0;

  // One-hot operand read: OR of every selected register
  always_comb begin
    reg_src  = '0;
    reg_dest = '0;
    for (int i = 0; i < 16; i++) begin
      if (inst_src[i])  reg_src  = reg_src  | reg_view[i];
      if (inst_dest[i]) reg_dest = reg_dest | reg_view[i];
    end
  end

  assign status = sr_to_status(sr);
  assign gie    = sr[SR_GIE];
  assign cpuoff = sr[SR_CPUOFF];
  assign oscoff = sr[SR_OSCOFF];
  assign scg1   = sr[SR_SCG1];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus a randomized
// run against a behavioural model of the architectural register state.
`timescale 1ns/1ps
module tb_register_file;

  logic        mclk = 1'b0;
  logic        reset_n;
  logic [15:0] alu_out;
  logic [3:0]  alu_stat;
  logic [3:0]  alu_stat_wr;
  logic        inst_bw;
  logic [15:0] inst_src;
  logic [15:0] inst_dest;
  logic        reg_dest_wr;
  logic        reg_incr;
  logic        reg_sp_wr;
  logic [15:0] reg_sp_val;
  logic        irq_acc;
  logic [15:0] pc;
  logic [15:0] reg_src;
  logic [15:0] reg_dest;
  logic [3:0]  status;
  logic        gie, cpuoff, oscoff, scg1;
  logic [15:0] pc_sw;
  logic        pc_sw_wr;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural state only
  logic [15:0] m_reg [16];
  logic [8:0]  m_sr;
  logic [15:0] m_pc_sw;
  logic        m_pc_sw_wr;

  register_file dut (
    .mclk(mclk), .reset_n(reset_n), .alu_out(alu_out), .alu_stat(alu_stat),
    .alu_stat_wr(alu_stat_wr), .inst_bw(inst_bw), .inst_src(inst_src),
    .inst_dest(inst_dest), .reg_dest_wr(reg_dest_wr), .reg_incr(reg_incr),
    .reg_sp_wr(reg_sp_wr), .reg_sp_val(reg_sp_val), .irq_acc(irq_acc), .pc(pc),
    .reg_src(reg_src), .reg_dest(reg_dest), .status(status), .gie(gie),
    .cpuoff(cpuoff), .oscoff(oscoff), .scg1(scg1), .pc_sw(pc_sw), .pc_sw_wr(pc_sw_wr)
  );

  always #50 mclk = ~mclk;

  initial begin
    #5000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic int onehot_idx(input logic [15:0] s);
    for (int i = 0; i < 16; i++) if (s[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] exp_val(input int idx);
    if (idx == 0) return pc;
    if (idx == 2) return {7'b0, m_sr};
    if (idx == 3) return 16'h0000;
    return m_reg[idx];
  endfunction

  function automatic logic [15:0] exp_read(input logic [15:0] sel);
    logic [15:0] v = 16'h0000;
    for (int i = 0; i < 16; i++) if (sel[i]) v = v | exp_val(i);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
    m_sr       = 9'h000;
    m_pc_sw    = 16'h0000;
    m_pc_sw_wr = 1'b0;
  endtask

  // Apply the updates lowest priority first so the highest-priority writer wins
  task automatic model_update();
    logic [15:0] nreg [16];
    logic [8:0]  nsr;
    logic [15:0] data;
    logic [15:0] sum;
    int          fpos [4];
    int          si, di;
    fpos = '{0, 1, 2, 8};
    for (int i = 0; i < 16; i++) nreg[i] = m_reg[i];
    nsr  = m_sr;
    data = inst_bw ? {8'h00, alu_out[7:0]} : alu_out;
    si   = onehot_idx(inst_src);
    di   = onehot_idx(inst_dest);
    for (int k = 0; k < 4; k++) if (alu_stat_wr[k]) nsr[fpos[k]] = alu_stat[k];
    if (reg_incr && si > 0 && si != 3) begin
      sum = exp_val(si) + ((inst_bw && si != 1) ? 16'd1 : 16'd2);
      if (si == 2) nsr = sum[8:0];
      else nreg[si] = sum;
    end
    if (reg_sp_wr) nreg[1] = reg_sp_val & 16'hFFFE;
    m_pc_sw_wr = 1'b0;
    if (reg_dest_wr && di >= 0) begin
      if (di == 0) begin
        m_pc_sw    = alu_out;
        m_pc_sw_wr = 1'b1;
      end else if (di == 1) nreg[1] = data & 16'hFFFE;
      else if (di == 2) nsr = data[8:0];
      else if (di != 3) nreg[di] = data;
    end
    if (irq_acc) begin
      nsr[3] = 1'b0; nsr[4] = 1'b0; nsr[5] = 1'b0; nsr[7] = 1'b0;
    end
    for (int i = 0; i < 16; i++) m_reg[i] = nreg[i];
    m_sr = nsr;
  endtask

  task automatic idle();
    alu_out = 16'h0000; alu_stat = 4'h0; alu_stat_wr = 4'h0; inst_bw = 1'b0;
    inst_src = 16'h0000; inst_dest = 16'h0000; reg_dest_wr = 1'b0; reg_incr = 1'b0;
    reg_sp_wr = 1'b0; reg_sp_val = 16'h0000; irq_acc = 1'b0;
  endtask

  task automatic step();
    model_update();
    @(posedge mclk);
    @(negedge mclk);
  endtask

  task automatic write_reg(input int idx, input logic [15:0] v);
    idle();
    inst_dest = 16'(1) << idx;
    alu_out = v;
    reg_dest_wr = 1'b1;
    step();
    idle();
  endtask

  task automatic read_reg(input int idx, output logic [15:0] v);
    inst_src = 16'(1) << idx;
    #1;
    v = reg_src;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    idle();
    pc = 16'h0000;
    reset_n = 1'b0;
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    for (int i = 1; i < 16; i++) begin
      read_reg(i, v);
      checks++;
      if (v !== 16'h0000) begin
        failures++;
        $display("[TB] FAIL reset_read R%0d: got %h expected 0000", i, v);
      end
    end
    checks++;
    if (status !== 4'b0000 || pc_sw_wr !== 1'b0 || pc_sw !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_outputs: status=%b pc_sw_wr=%b pc_sw=%h expected 0 0 0000", status, pc_sw_wr, pc_sw);
    end
    idle();
    model_reset();
    reset_n = 1'b1;
    @(negedge mclk);
  endtask

  task automatic test_byte_write();
    logic [15:0] v;
    idle();
    inst_dest = 16'(1) << 5; alu_out = 16'hA5C3; inst_bw = 1'b1; reg_dest_wr = 1'b1;
    inst_src = 16'(1) << 5;
    #1;
    checks++;
    if (reg_src !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL no_bypass R5: got %h expected 0000", reg_src);
    end
    step();
    idle();
    read_reg(5, v);
    checks++;
    if (v !== 16'h00C3) begin
      failures++;
      $display("[TB] FAIL byte_write R5: got %h expected 00C3", v);
    end
    write_reg(5, 16'hA5C3);
    read_reg(5, v);
    checks++;
    if (v !== 16'hA5C3) begin
      failures++;
      $display("[TB] FAIL word_write R5: got %h expected A5C3", v);
    end
  endtask

  task automatic test_autoincrement();
    logic [15:0] v;
    logic [15:0] exp_tbl [3];
    int          reg_tbl [3];
    logic [15:0] init_tbl [3];
    logic        bw_tbl [3];
    reg_tbl = '{6, 7, 1};
    init_tbl = '{16'hFFFE, 16'h00FF, 16'h0200};
    bw_tbl = '{1'b0, 1'b1, 1'b1};
    exp_tbl = '{16'h0000, 16'h0100, 16'h0202};
    for (int t = 0; t < 3; t++) begin
      write_reg(reg_tbl[t], init_tbl[t]);
      inst_src = 16'(1) << reg_tbl[t]; inst_bw = bw_tbl[t]; reg_incr = 1'b1;
      step();
      idle();
      read_reg(reg_tbl[t], v);
      checks++;
      if (v !== exp_tbl[t]) begin
        failures++;
        $display("[TB] FAIL autoinc R%0d: got %h expected %h", reg_tbl[t], v, exp_tbl[t]);
      end
    end
  endtask

  task automatic test_sp_load();
    logic [15:0] v;
    idle();
    reg_sp_wr = 1'b1; reg_sp_val = 16'h1235;
    step();
    idle();
    read_reg(1, v);
    checks++;
    if (v !== 16'h1234) begin
      failures++;
      $display("[TB] FAIL sp_load: got %h expected 1234", v);
    end
    reg_sp_wr = 1'b1; reg_sp_val = 16'h2222;
    inst_dest = 16'(1) << 1; alu_out = 16'h5001; reg_dest_wr = 1'b1;
    step();
    idle();
    read_reg(1, v);
    checks++;
    if (v !== 16'h5000) begin
      failures++;
      $display("[TB] FAIL sp_dest_priority: got %h expected 5000", v);
    end
  endtask

  task automatic test_flags();
    write_reg(2, 16'h0000);
    alu_stat = 4'b1011; alu_stat_wr = 4'hF;
    step();
    idle();
    checks++;
    if (status !== 4'b1011) begin
      failures++;
      $display("[TB] FAIL flag_write: status=%b expected 1011", status);
    end
    alu_stat = 4'b1011; alu_stat_wr = 4'hF;
    inst_dest = 16'(1) << 2; alu_out = 16'h0008; reg_dest_wr = 1'b1;
    step();
    idle();
    checks++;
    if (status !== 4'b0000 || gie !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sr_write_over_flags: status=%b gie=%b expected 0000 1", status, gie);
    end
  endtask

  task automatic test_irq();
    logic [15:0] v;
    write_reg(2, 16'h00F9);
    irq_acc = 1'b1;
    step();
    idle();
    read_reg(2, v);
    checks++;
    if (v !== 16'h0041 || gie !== 1'b0 || cpuoff !== 1'b0 || oscoff !== 1'b0 || scg1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL irq_clear: SR=%h gie=%b expected 0041 0", v, gie);
    end
    irq_acc = 1'b1;
    inst_dest = 16'(1) << 2; alu_out = 16'h0008; reg_dest_wr = 1'b1;
    step();
    idle();
    read_reg(2, v);
    checks++;
    if (gie !== 1'b0 || v !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL irq_over_sr_write: gie=%b SR=%h expected 0 0000", gie, v);
    end
  endtask

  task automatic test_pc_load();
    logic [15:0] v;
    pc = 16'h4400;
    read_reg(0, v);
    checks++;
    if (v !== 16'h4400) begin
      failures++;
      $display("[TB] FAIL read_r0: got %h expected 4400", v);
    end
    write_reg(0, 16'hF000);
    checks++;
    if (pc_sw_wr !== 1'b1 || pc_sw !== 16'hF000) begin
      failures++;
      $display("[TB] FAIL pc_load_pulse: pc_sw_wr=%b pc_sw=%h expected 1 F000", pc_sw_wr, pc_sw);
    end
    step();
    checks++;
    if (pc_sw_wr !== 1'b0 || pc_sw !== 16'hF000) begin
      failures++;
      $display("[TB] FAIL pc_load_hold: pc_sw_wr=%b pc_sw=%h expected 0 F000", pc_sw_wr, pc_sw);
    end
    write_reg(3, 16'h1234);
    read_reg(3, v);
    checks++;
    if (v !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL r3_constant: got %h expected 0000", v);
    end
  endtask

  task automatic test_random();
    int di, si;
    for (int n = 0; n < 300; n++) begin
      alu_out     = 16'($urandom);
      alu_stat    = 4'($urandom);
      alu_stat_wr = 4'($urandom);
      inst_bw     = 1'($urandom);
      di          = int'($urandom_range(0, 15));
      si          = int'($urandom_range(0, 15));
      inst_dest   = 16'(1) << di;
      inst_src    = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'(1) << si;
      reg_dest_wr = ($urandom_range(0, 2) == 0);
      reg_incr    = (si != 2) && ($urandom_range(0, 2) == 0);
      reg_sp_wr   = ($urandom_range(0, 5) == 0);
      reg_sp_val  = 16'($urandom);
      irq_acc     = ($urandom_range(0, 9) == 0);
      pc          = 16'($urandom);
      #1;
      checks++;
      if (reg_src !== exp_read(inst_src)) begin
        failures++;
        $display("[TB] FAIL rand_src #%0d: got %h expected %h", n, reg_src, exp_read(inst_src));
      end
      checks++;
      if (reg_dest !== exp_read(inst_dest)) begin
        failures++;
        $display("[TB] FAIL rand_dest #%0d: got %h expected %h", n, reg_dest, exp_read(inst_dest));
      end
      checks++;
      if (status !== {m_sr[8], m_sr[2], m_sr[1], m_sr[0]} ||
          {gie, cpuoff, oscoff, scg1} !== {m_sr[3], m_sr[4], m_sr[5], m_sr[7]}) begin
        failures++;
        $display("[TB] FAIL rand_sr #%0d: status=%b ctl=%b expected SR=%h", n, status,
                 {gie, cpuoff, oscoff, scg1}, m_sr);
      end
      checks++;
      if (pc_sw_wr !== m_pc_sw_wr || pc_sw !== m_pc_sw) begin
        failures++;
        $display("[TB] FAIL rand_pc_sw #%0d: wr=%b val=%h expected %b %h", n, pc_sw_wr, pc_sw,
                 m_pc_sw_wr, m_pc_sw);
      end
      step();
    end
    idle();
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] v;
    write_reg(0, 16'hBEEF);
    write_reg(9, 16'h7777);
    inst_dest = 16'(1) << 5; alu_out = 16'h1111; reg_dest_wr = 1'b1;
    alu_stat = 4'hF; alu_stat_wr = 4'hF;
    #10;
    reset_n = 1'b0;
    @(posedge mclk);
    @(negedge mclk);
    idle();
    read_reg(9, v);
    checks++;
    if (v !== 16'h0000 || status !== 4'b0000 || pc_sw_wr !== 1'b0 || pc_sw !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_mid_write: R9=%h status=%b pc_sw_wr=%b pc_sw=%h expected all 0",
               v, status, pc_sw_wr, pc_sw);
    end
    model_reset();
    reset_n = 1'b1;
    step();
    read_reg(5, v);
    checks++;
    if (v !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL aborted_write R5: got %h expected 0000", v);
    end
  endtask

  initial begin
    $display("[TB] register_file bench starting");
    test_reset();
    test_byte_write();
    test_autoincrement();
    test_sp_load();
    test_flags();
    test_irq();
    test_pc_load();
    test_random();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
